// File: rtl/uart_bus_master_if.sv
// Memory-bus signals between the UART debug bridge (master) and the arbiter/responders (slave).
// Signal names keep their direction suffix as seen from the bridge.
interface uart_bus_master_if;
   logic        bus_req_out;
   logic        bus_grant_in;
   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;
   logic        fault_in;

   modport master (
      output bus_req_out, address_out, read_out, write_out, write_mask_out, write_value_out,
      input  bus_grant_in, read_value_in, ready_in, fault_in
   );

   modport slave (
      input  bus_req_out, address_out, read_out, write_out, write_mask_out, write_value_out,
      output bus_grant_in, read_value_in, ready_in, fault_in
   );
endinterface

// File: rtl/uart_bus_master.sv
// UART debug bridge: decodes 'R'/'W' byte frames, runs one memory-bus transaction per frame
// as a third bus initiator, and streams back a status byte plus read data.
module uart_bus_master #(
   parameter int unsigned BUS_TIMEOUT   = 1024,
   parameter int unsigned FRAME_TIMEOUT = 36000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data_in,
   input  logic       rx_valid_in,
   output logic [7:0] tx_data_out,
   output logic       tx_valid_out,
   input  logic       tx_ready_in,
   output logic       busy_out,
   uart_bus_master_if.master bus
);

   localparam int unsigned GAP_W = $clog2(FRAME_TIMEOUT + 1);
   localparam int unsigned BUS_W = $clog2(BUS_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(FRAME_TIMEOUT);
   localparam logic [BUS_W-1:0] BUS_LIMIT = BUS_W'(BUS_TIMEOUT - 1);

   localparam logic [7:0] CMD_READ   = 8'h52;
   localparam logic [7:0] CMD_WRITE  = 8'h57;
   localparam logic [7:0] ST_OK      = 8'h4B;
   localparam logic [7:0] ST_FAULT   = 8'h46;
   localparam logic [7:0] ST_TIMEOUT = 8'h54;
   localparam logic [7:0] ST_UNKNOWN = 8'h3F;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_BUS, S_RESP} state_e;

   state_e           state_q, state_d;
   logic             is_write_q, is_write_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [BUS_W-1:0] bus_cnt_q, bus_cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [2:0]       resp_left_q, resp_left_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             bus_req_q, bus_req_d;
   logic             read_q, read_d;
   logic             write_q, write_d;
   logic [31:0]      address_q, address_d;
   logic [3:0]       mask_q, mask_d;
   logic [31:0]      wvalue_q, wvalue_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
      state_d     = state_q;
      is_write_d  = is_write_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      bus_cnt_d   = bus_cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_left_d = resp_left_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      bus_req_d   = bus_req_q;
      read_d      = read_q;
      write_d     = write_q;
      address_d   = address_q;
      mask_d      = mask_q;
      wvalue_d    = wvalue_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid_in) begin
               if (rx_data_in == CMD_READ || rx_data_in == CMD_WRITE) begin
                  is_write_d = (rx_data_in == CMD_WRITE);
                  cnt_d      = 2'd0;
                  gap_d      = '0;
                  state_d    = S_ADDR;
               end else begin
                  tx_valid_d  = 1'b1;
                  tx_data_d   = ST_UNKNOWN;
                  resp_left_d = 3'd0;
                  state_d     = S_RESP;
               end
            end
         end

         S_ADDR, S_DATA: begin
            if (rx_valid_in) begin
               gap_d = '0;
               cnt_d = cnt_q + 2'd1;
               // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at [7:0].
               if (state_q == S_ADDR) addr_d  = {rx_data_in, addr_q[31:8]};
               else                   wdata_d = {rx_data_in, wdata_q[31:8]};
               if (cnt_q == 2'd3) begin
                  if (state_q == S_ADDR && is_write_q) begin
                     state_d = S_DATA;
                  end else begin
                     state_d   = S_REQ;
                     bus_req_d = 1'b1;
                  end
               end
            end else if (gap_q == GAP_LIMIT) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         S_REQ: begin
            bus_cnt_d = '0;
            if (bus.bus_grant_in) begin
               state_d   = S_BUS;
               read_d    = !is_write_q;
               write_d   = is_write_q;
               address_d = addr_q;
               mask_d    = is_write_q ? 4'b1111 : 4'b0000;
               wvalue_d  = is_write_q ? wdata_q : 32'd0;
            end
         end

         S_BUS: begin
            if (bus.ready_in || bus_cnt_q == BUS_LIMIT) begin
               read_d      = 1'b0;
               write_d     = 1'b0;
               bus_req_d   = 1'b0;
               address_d   = '0;
               mask_d      = '0;
               wvalue_d    = '0;
               tx_valid_d  = 1'b1;
               resp_left_d = 3'd0;
               state_d     = S_RESP;
               if (bus.ready_in) begin
                  rdata_d   = bus.read_value_in;
                  tx_data_d = bus.fault_in ? ST_FAULT : ST_OK;
                  if (!is_write_q && !bus.fault_in) resp_left_d = 3'd4;
               end else begin
                  tx_data_d = ST_TIMEOUT;
               end
            end else begin
               bus_cnt_d = bus_cnt_q + 1'b1;
            end
         end

         S_RESP: begin
            if (tx_valid_q && tx_ready_in) begin
               if (resp_left_q == 3'd0) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  tx_data_d   = rdata_q[7:0];
                  rdata_d     = {8'd0, rdata_q[31:8]};
                  resp_left_d = resp_left_q - 3'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         is_write_q  <= 1'b0;
         cnt_q       <= '0;
         gap_q       <= '0;
         bus_cnt_q   <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         resp_left_q <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         bus_req_q   <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= '0;
         mask_q      <= '0;
         wvalue_q    <= '0;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         bus_cnt_q   <= bus_cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_left_q <= resp_left_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         bus_req_q   <= bus_req_d;
         read_q      <= read_d;
         write_q     <= write_d;
         address_q   <= address_d;
         mask_q      <= mask_d;
         wvalue_q    <= wvalue_d;
      end
   end

   assign tx_data_out         = tx_data_q;
   assign tx_valid_out        = tx_valid_q;
   assign busy_out            = (state_q != S_IDLE);
   assign bus.bus_req_out     = bus_req_q;
   assign bus.read_out        = read_q;
   assign bus.write_out       = write_q;
   assign bus.address_out     = address_q;
   assign bus.write_mask_out  = mask_q;
   assign bus.write_value_out = wvalue_q;

endmodule
